// File: rtl/alu_cmd_sequencer_if.sv
// Host/ALU bundle for alu_cmd_sequencer: register preload, command and response
// channels, the operand/result path to the external ALU, and the status flags.
interface alu_cmd_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 8
);
  localparam int unsigned AW = $clog2(NREGS);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [AW-1:0]     cmd_rd;
  logic [AW-1:0]     cmd_ra;
  logic [AW-1:0]     cmd_rb;

  logic [DATA_W-1:0] alu_x;
  logic [DATA_W-1:0] alu_y;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic              alu_borrow;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;
  logic              rsp_borrow;

  logic              flag_c;
  logic              flag_b;
  logic              flag_z;

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb,
    output cmd_ready,
    output alu_x, alu_y, alu_sel,
    input  alu_out, alu_carry, alu_borrow,
    output rsp_valid, rsp_data, rsp_carry, rsp_borrow,
    input  rsp_ready,
    output flag_c, flag_b, flag_z
  );

  modport master (
    output wr_en, wr_addr, wr_data,
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb,
    input  cmd_ready,
    input  alu_x, alu_y, alu_sel,
    output alu_out, alu_carry, alu_borrow,
    input  rsp_valid, rsp_data, rsp_carry, rsp_borrow,
    output rsp_ready,
    input  flag_c, flag_b, flag_z
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Register-file command sequencer driving an external combinational ALU, one op in flight.
// Optional sticky status flags are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_cmd_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e            r_state;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_alu_x;
  logic [DATA_W-1:0] r_alu_y;
  logic [3:0]        r_alu_sel;
  logic [AW-1:0]     r_rd;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_carry;
  logic              r_rsp_borrow;

  logic w_accept;
  logic w_issue;

  assign w_accept = (r_state == StIdle) && bus.cmd_valid;
  assign w_issue  = (r_state == StIssue);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_alu_x      <= '0;
      r_alu_y      <= '0;
      r_alu_sel    <= '0;
      r_rd         <= '0;
      r_rsp_data   <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_borrow <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_alu_x   <= r_regs[bus.cmd_ra];
            r_alu_y   <= r_regs[bus.cmd_rb];
            r_alu_sel <= bus.cmd_op;
            r_rd      <= bus.cmd_rd;
            r_state   <= StIssue;
          end
        end
        StIssue: begin
          r_rsp_data   <= bus.alu_out;
          r_rsp_carry  <= bus.alu_carry;
          r_rsp_borrow <= bus.alu_borrow;
          r_state      <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Writeback is assigned last so it overrides a same-index host write on the ISSUE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (bus.wr_en) r_regs[bus.wr_addr] <= bus.wr_data;
      if (w_issue) r_regs[r_rd] <= bus.alu_out;
    end
  end

  assign bus.cmd_ready  = (r_state == StIdle);
  assign bus.rsp_valid  = (r_state == StResp);
  assign bus.alu_x      = r_alu_x;
  assign bus.alu_y      = r_alu_y;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_carry  = r_rsp_carry;
  assign bus.rsp_borrow = r_rsp_borrow;

`ifdef ALU_SEQ_FLAGS_EN
  localparam logic [3:0] OpClrFlags = 4'b1110;

  logic r_flag_c;
  logic r_flag_b;
  logic r_flag_z;

  // The clearing command is cleared at accept, so its own ISSUE result still accumulates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_c <= 1'b0;
      r_flag_b <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (w_accept && (bus.cmd_op == OpClrFlags)) begin
      r_flag_c <= 1'b0;
      r_flag_b <= 1'b0;
    end else if (w_issue) begin
      r_flag_c <= r_flag_c | bus.alu_carry;
      r_flag_b <= r_flag_b | bus.alu_borrow;
      r_flag_z <= (bus.alu_out == '0);
    end
  end

  assign bus.flag_c = r_flag_c;
  assign bus.flag_b = r_flag_b;
  assign bus.flag_z = r_flag_z;
`else
  assign bus.flag_c = 1'b0;
  assign bus.flag_b = 1'b0;
  assign bus.flag_z = 1'b0;
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer with a behavioural ALU and
// register-file reference model.
module tb_alu_cmd_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DATA_W(DW), .NREGS(NR)) bus ();

  alu_cmd_sequencer #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALU: {borrow, carry, result}
  function automatic logic [33:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] op);
    logic [32:0] s;
    logic [33:0] r;
    s = {1'b0, x} + {1'b0, y};
    case (op)
      4'd0, 4'd14: r = {1'b0, s};
      4'd1:        r = {(x < y), 1'b0, x - y};
      4'd2:        r = {2'b00, x & y};
      4'd3:        r = {2'b00, x | y};
      4'd4:        r = {2'b00, x ^ y};
      4'd5:        r = {2'b00, y};
      default:     r = {2'b00, ~x};
    endcase
    return r;
  endfunction

  assign {bus.alu_borrow, bus.alu_carry, bus.alu_out} = alu_f(bus.alu_x, bus.alu_y, bus.alu_sel);

  logic [31:0] m_regs [NR];
  logic        m_fc, m_fb, m_fz;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_fc = 1'b0;
    m_fb = 1'b0;
    m_fz = 1'b0;
  endtask

  task automatic check_flags();
`ifdef ALU_SEQ_FLAGS_EN
    check_eq("flag_c", {31'd0, bus.flag_c}, {31'd0, m_fc});
    check_eq("flag_b", {31'd0, bus.flag_b}, {31'd0, m_fb});
    check_eq("flag_z", {31'd0, bus.flag_z}, {31'd0, m_fz});
`else
    check_eq("flags_off", {29'd0, bus.flag_c, bus.flag_b, bus.flag_z}, 32'd0);
`endif
  endtask

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    m_regs[a] = d;
  endtask

  // wmode: 0 none, 1 host write to ra on the accept edge, 2 host write to rd on the ISSUE edge
  task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input int stall, input int wmode,
                         input logic [31:0] wdata);
    logic [33:0] r;
    logic [31:0] xa, yb;
    @(negedge clk);
    check_eq("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    xa = m_regs[ra];
    yb = m_regs[rb];
    r  = alu_f(xa, yb, op);
    if (wmode == 1) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = ra;
      bus.wr_data = wdata;
      m_regs[ra]  = wdata;
    end
    if (op == 4'b1110) begin
      m_fc = 1'b0;
      m_fb = 1'b0;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.wr_en     = 1'b0;
    check_eq("alu_x", bus.alu_x, xa);
    check_eq("alu_y", bus.alu_y, yb);
    check_eq("alu_sel", {28'd0, bus.alu_sel}, {28'd0, op});
    check_eq("issue_busy", {30'd0, bus.cmd_ready, bus.rsp_valid}, 32'd0);
    if (wmode == 2) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = rd;
      bus.wr_data = wdata;
    end
    @(negedge clk);
    bus.wr_en  = 1'b0;
    m_regs[rd] = r[31:0];
    m_fc = m_fc | r[32];
    m_fb = m_fb | r[33];
    m_fz = (r[31:0] == 32'd0);
    check_eq("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_eq("rsp_data", bus.rsp_data, r[31:0]);
    check_eq("rsp_flags", {30'd0, bus.rsp_borrow, bus.rsp_carry}, {30'd0, r[33:32]});
    check_eq("resp_busy", {31'd0, bus.cmd_ready}, 32'd0);
    check_flags();
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_hold", {bus.rsp_valid, bus.cmd_ready, 30'd0}, {2'b10, 30'd0});
      check_eq("stall_data", bus.rsp_data, r[31:0]);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("rsp_done", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_ra = '0; bus.cmd_rb = '0;
    bus.rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check_eq("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_carry, bus.rsp_borrow}, 32'd0);
    check_eq("rst_data", bus.rsp_data, 32'd0);
    check_eq("rst_alu", bus.alu_x | bus.alu_y | {28'd0, bus.alu_sel}, 32'd0);
    check_flags();

    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd3);
    run_cmd(4'd0, 3'd3, 3'd1, 3'd2, 0, 0, '0);
    run_cmd(4'd5, 3'd0, 3'd3, 3'd3, 0, 0, '0);

    host_write(3'd1, 32'd3);
    host_write(3'd2, 32'd5);
    run_cmd(4'd1, 3'd4, 3'd1, 3'd2, 0, 0, '0);
    run_cmd(4'd0, 3'd5, 3'd1, 3'd2, 0, 0, '0);

    host_write(3'd1, 32'hFFFF_FFFF);
    host_write(3'd2, 32'd1);
    run_cmd(4'd0, 3'd6, 3'd1, 3'd2, 0, 0, '0);

    run_cmd(4'd3, 3'd7, 3'd4, 3'd5, 5, 0, '0);
    run_cmd(4'd0, 3'd3, 3'd1, 3'd2, 0, 2, 32'hAA);
    run_cmd(4'd4, 3'd0, 3'd3, 3'd3, 0, 0, '0);
    run_cmd(4'd2, 3'd2, 3'd2, 3'd2, 0, 1, 32'h77);
    run_cmd(4'd14, 3'd5, 3'd5, 3'd2, 1, 0, '0);

    // Reset during ISSUE drops the response and clears the register file.
    host_write(3'd4, 32'h1234);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 4'd0; bus.cmd_rd = 3'd4; bus.cmd_ra = 3'd4; bus.cmd_rb = 3'd4;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_eq("midrst_state", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
    check_eq("midrst_data", bus.rsp_data | bus.alu_x, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst_norsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    run_cmd(4'd0, 3'd1, 3'd4, 3'd4, 0, 0, '0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) host_write(3'($urandom_range(0, 7)), $urandom);
      run_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
